// File: rtl/paramreadback.sv
// Snapshots a packed NUM_BLOCKS x WIDTH parameter bus on load and replays it one word per read strobe.
// Latency: 1 cycle from load to word 0 and from each read to the next word; all outputs registered.
// Backpressure: none; read is the only advance, a read with nothing captured raises sticky underflow.
module paramreadback #(
   parameter int NUM_BLOCKS = 64,
   parameter int WIDTH      = 16,
   localparam int IDX_W     = $clog2(NUM_BLOCKS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_BLOCKS*WIDTH-1:0] combinedin,
   input  logic                        load,
   input  logic                        read,
   output logic [WIDTH-1:0]            dataout,
   output logic                        valid,
   output logic [IDX_W-1:0]            index,
   output logic                        done,
   output logic                        underflow
);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

   state_t                      state;
   state_t                      state_nxt;
   logic [NUM_BLOCKS*WIDTH-1:0] snapshot;
   logic [WIDTH-1:0]            snap_word [NUM_BLOCKS];
   logic [IDX_W-1:0]            idx_inc;

   logic [WIDTH-1:0]            dataout_nxt;
   logic                        valid_nxt;
   logic [IDX_W-1:0]            index_nxt;
   logic                        done_nxt;
   logic                        underflow_nxt;

   // Split the snapshot into words so the output mux is a plain array select.
   for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_word
      assign snap_word[k] = snapshot[k*WIDTH +: WIDTH];
   end

   // Only ever used while index < LAST_IDX, so it never runs past the last word.
   assign idx_inc = index + IDX_W'(1);

   // Snapshot register: the live bus is ignored except in the load cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         snapshot <= '0;
      end else if (load) begin
         snapshot <= combinedin;
      end
   end

   // State and registered outputs; reset aborts any stream without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         dataout   <= '0;
         valid     <= 1'b0;
         index     <= '0;
         done      <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= state_nxt;
         dataout   <= dataout_nxt;
         valid     <= valid_nxt;
         index     <= index_nxt;
         done      <= done_nxt;
         underflow <= underflow_nxt;
      end
   end

   // Next state and next outputs; load has priority over read in every state.
   always_comb begin
      state_nxt     = state;
      dataout_nxt   = dataout;
      valid_nxt     = valid;
      index_nxt     = index;
      done_nxt      = 1'b0;
      underflow_nxt = underflow;

      if (load) begin
         // Word 0 comes straight from the bus since the snapshot is written this same edge.
         state_nxt   = STREAM;
         dataout_nxt = combinedin[WIDTH-1:0];
         valid_nxt   = 1'b1;
         index_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (read) begin
                  underflow_nxt = 1'b1;
               end
            end
            STREAM: begin
               if (read) begin
                  if (index == LAST_IDX) begin
                     state_nxt   = IDLE;
                     dataout_nxt = '0;
                     valid_nxt   = 1'b0;
                     index_nxt   = '0;
                     done_nxt    = 1'b1;
                  end else begin
                     dataout_nxt = snap_word[idx_inc];
                     index_nxt   = idx_inc;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_paramreadback.sv
// Self-checking bench for paramreadback against a word-list reference model.
// Latency: model expectations are compared at the falling edge after each rising edge.
// Backpressure: not applicable; the bench drives load/read strobes directly.
module tb_paramreadback;

   localparam int NB = 64;
   localparam int W  = 16;

   logic            clk;
   logic            reset;
   logic [NB*W-1:0] combinedin;
   logic            load;
   logic            read;
   logic [W-1:0]    dataout;
   logic            valid;
   logic [5:0]      index;
   logic            done;
   logic            underflow;

   int n_checks;
   int n_errors;

   // Reference model: a captured list of words, a read position and flags.
   logic [W-1:0] m_words [NB];
   bit           m_active;
   int           m_pos;
   bit           m_done;
   bit           m_under;

   logic [24:0]  obs;

   paramreadback #(.NUM_BLOCKS(NB), .WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .combinedin (combinedin),
      .load       (load),
      .read       (read),
      .dataout    (dataout),
      .valid      (valid),
      .index      (index),
      .done       (done),
      .underflow  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {dataout, valid, index, done, underflow};

   function automatic logic [24:0] exp_vec();
      logic [W-1:0] w;
      w = m_active ? m_words[m_pos] : '0;
      return {w, m_active, 6'(m_pos), m_done, m_under};
   endfunction

   // Advance one clock: update the model with the inputs seen at the rising edge,
   // then return at the falling edge where outputs are sampled.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_active = 0;
         m_pos    = 0;
         m_done   = 0;
         m_under  = 0;
      end else begin
         m_done = 0;
         if (load) begin
            for (int k = 0; k < NB; k++) m_words[k] = combinedin[k*W +: W];
            m_active = 1;
            m_pos    = 0;
         end else if (read) begin
            if (!m_active) begin
               m_under = 1;
            end else if (m_pos == NB - 1) begin
               m_active = 0;
               m_pos    = 0;
               m_done   = 1;
            end else begin
               m_pos++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic fill_pattern(input logic [15:0] base);
      for (int k = 0; k < NB; k++) combinedin[k*W +: W] = base + 16'(k);
   endtask

   task automatic fill_random();
      for (int k = 0; k < NB; k++) combinedin[k*W +: W] = 16'($urandom);
   endtask

   task automatic test_reset();
      reset = 1; load = 0; read = 0;
      combinedin = '0;
      tick();
      tick();
      reset = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (obs !== 25'd0) begin
            n_errors++;
            $display("FAIL reset_idle cycle=%0d got %h required 0", i, obs);
         end
      end
   endtask

   task automatic test_full_stream();
      int dones;
      dones = 0;
      fill_pattern(16'hA000);
      load = 1;
      tick();
      load = 0;
      for (int i = 0; i < NB; i++) begin
         n_checks++;
         if (dataout !== 16'hA000 + 16'(i) || valid !== 1'b1 || index !== 6'(i) || done !== 1'b0) begin
            n_errors++;
            $display("FAIL full_stream word=%0d got dout=%h v=%b idx=%0d done=%b required dout=%h v=1 idx=%0d done=0",
                     i, dataout, valid, index, done, 16'hA000 + 16'(i), i);
         end
         read = 1;
         tick();
         if (done) dones++;
      end
      read = 0;
      n_checks++;
      if (dones !== 1 || obs !== exp_vec()) begin
         n_errors++;
         $display("FAIL full_stream_done dones=%0d got %h required 1 pulse and %h", dones, obs, exp_vec());
      end
      tick();
      n_checks++;
      if (valid !== 1'b0 || index !== 6'd0 || done !== 1'b0 || dataout !== 16'h0) begin
         n_errors++;
         $display("FAIL full_stream_after got v=%b idx=%0d done=%b dout=%h required 0 0 0 0",
                  valid, index, done, dataout);
      end
   endtask

   task automatic test_midstream_change();
      fill_pattern(16'hA000);
      load = 1;
      tick();
      load = 0;
      read = 1;
      repeat (3) tick();
      read = 0;
      fill_random();
      tick();
      n_checks++;
      if (dataout !== 16'hA003 || index !== 6'd3 || obs !== exp_vec()) begin
         n_errors++;
         $display("FAIL mid_change got dout=%h idx=%0d required dout=a003 idx=3", dataout, index);
      end
      load = 1;
      read = 1;
      tick();
      load = 0;
      read = 0;
      n_checks++;
      if (dataout !== combinedin[W-1:0] || index !== 6'd0 || done !== 1'b0 || underflow !== 1'b0
          || valid !== 1'b1 || obs !== exp_vec()) begin
         n_errors++;
         $display("FAIL load_with_read got %h required dout=%h idx=0 done=0 uf=0 v=1",
                  obs, combinedin[W-1:0]);
      end
   endtask

   task automatic test_underflow();
      int dones;
      dones = 0;
      reset = 1;
      tick();
      reset = 0;
      read = 1;
      tick();
      read = 0;
      n_checks++;
      if (underflow !== 1'b1 || valid !== 1'b0 || dataout !== 16'h0 || index !== 6'd0) begin
         n_errors++;
         $display("FAIL underflow_set got uf=%b v=%b dout=%h idx=%0d required 1 0 0 0",
                  underflow, valid, dataout, index);
      end
      fill_random();
      load = 1;
      tick();
      load = 0;
      read = 1;
      for (int i = 0; i < NB; i++) begin
         tick();
         if (done) dones++;
         n_checks++;
         if (obs !== exp_vec() || underflow !== 1'b1) begin
            n_errors++;
            $display("FAIL underflow_stream step=%0d got %h required %h", i, obs, exp_vec());
         end
      end
      read = 0;
      n_checks++;
      if (dones !== 1) begin
         n_errors++;
         $display("FAIL underflow_stream_done got %0d pulses required 1", dones);
      end
      reset = 1;
      tick();
      reset = 0;
      n_checks++;
      if (underflow !== 1'b0 || obs !== 25'd0) begin
         n_errors++;
         $display("FAIL underflow_clear got %h required 0", obs);
      end
   endtask

   task automatic test_random_gaps();
      int dones;
      int gap;
      logic [W-1:0] words [NB];
      dones = 0;
      fill_random();
      for (int k = 0; k < NB; k++) words[k] = combinedin[k*W +: W];
      load = 1;
      tick();
      load = 0;
      fill_random();
      for (int w = 0; w < NB; w++) begin
         gap = int'($urandom_range(0, 4));
         for (int g = 0; g < gap; g++) begin
            tick();
            if (done) dones++;
            n_checks++;
            if (dataout !== words[w] || obs !== exp_vec()) begin
               n_errors++;
               $display("FAIL gap_hold word=%0d got dout=%h required %h", w, dataout, words[w]);
            end
         end
         read = 1;
         tick();
         read = 0;
         if (done) dones++;
         n_checks++;
         if (obs !== exp_vec() || done !== (w == NB - 1)) begin
            n_errors++;
            $display("FAIL gap_read word=%0d got %h required %h", w, obs, exp_vec());
         end
      end
      n_checks++;
      if (dones !== 1) begin
         n_errors++;
         $display("FAIL gap_done got %0d pulses required 1", dones);
      end
   endtask

   task automatic test_reset_midstream();
      fill_random();
      load = 1;
      tick();
      load = 0;
      read = 1;
      repeat (20) tick();
      n_checks++;
      if (index !== 6'd20) begin
         n_errors++;
         $display("FAIL abort_setup got idx=%0d required 20", index);
      end
      reset = 1;
      tick();
      reset = 0;
      read = 0;
      n_checks++;
      if (valid !== 1'b0 || index !== 6'd0 || dataout !== 16'h0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort got v=%b idx=%0d dout=%h done=%b required 0 0 0 0",
                  valid, index, dataout, done);
      end
      fill_random();
      load = 1;
      tick();
      load = 0;
      read = 1;
      for (int i = 0; i < NB; i++) begin
         tick();
         n_checks++;
         if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL abort_restream step=%0d got %h required %h", i, obs, exp_vec());
         end
      end
      read = 0;
   endtask

   task automatic test_back_to_back();
      fill_random();
      load = 1;
      tick();
      load = 0;
      read = 1;
      repeat (NB) tick();
      read = 0;
      n_checks++;
      if (done !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_done got done=%b required 1", done);
      end
      fill_random();
      load = 1;
      tick();
      load = 0;
      n_checks++;
      if (obs !== exp_vec() || dataout !== combinedin[W-1:0] || valid !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_reload got %h required %h", obs, exp_vec());
      end
      for (int i = 0; i < NB; i++) begin
         read = ($urandom_range(0, 3) != 0);
         tick();
         n_checks++;
         if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL b2b_stream step=%0d got %h required %h", i, obs, exp_vec());
         end
      end
      read = 0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_active = 0;
      m_pos    = 0;
      m_done   = 0;
      m_under  = 0;
      reset      = 1;
      load       = 0;
      read       = 0;
      combinedin = '0;
      test_reset();
      test_full_stream();
      test_midstream_change();
      test_underflow();
      test_random_gaps();
      test_reset_midstream();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
